// File: rtl/mips_arb_pkg.sv
// Shared types and constants for the MIPS burst arbiter slice.
package mips_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        GAP
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic id;
        logic last;
    } tag_t;

    localparam logic [5:0] R_TYPE = 6'b000000;
    localparam logic [5:0] ADDI   = 6'b001000;

endpackage

// File: rtl/mips_tag_pipe.sv
// Tag shift register tracking issued beats; its tail lines up with core_out_valid
// and routes each core result back to the issuing requester.
module mips_tag_pipe
    import mips_arb_pkg::*;
#(
    parameter int unsigned CORE_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_valid,
    input  logic push_id,
    input  logic push_last,
    input  logic core_out_valid,
    input  logic core_instruction_fail,
    output logic rsp_valid,
    output logic rsp_id,
    output logic rsp_fail,
    output logic rsp_last,
    output logic err_orphan
);

    tag_t pipe [CORE_LAT+1];
    tag_t tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= CORE_LAT; i++) begin
                pipe[i] <= '0;
            end
            err_orphan <= 1'b0;
        end else begin
            pipe[0] <= '{valid: push_valid, id: push_id, last: push_last};
            for (int unsigned i = 1; i <= CORE_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (core_out_valid && !tail.valid) begin
                err_orphan <= 1'b1;
            end
        end
    end

    // A tail entry with no matching core_out_valid simply falls off the end.
    always_comb begin
        tail      = pipe[CORE_LAT];
        rsp_valid = core_out_valid && tail.valid;
        rsp_id    = rsp_valid && tail.id;
        rsp_last  = rsp_valid && tail.last;
        rsp_fail  = rsp_valid && core_instruction_fail;
    end

endmodule

// File: rtl/mips_burst_arbiter.sv
// Two-requester burst arbiter feeding a MIPS execute core with gap cycles between bursts.
// Define FIXED_PRIO_EN to replace round-robin with fixed priority for requester 0.
module mips_burst_arbiter
    import mips_arb_pkg::*;
#(
    parameter int unsigned CORE_LAT   = 2,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_instr,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_instr,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic        core_in_valid,
    output logic [31:0] core_instruction,
    input  logic        core_out_valid,
    input  logic        core_instruction_fail,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic        rsp_fail,
    output logic        rsp_last,
    output logic        err_break,
    output logic        err_orphan
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    arb_state_t       state;
    logic             owner;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [GAP_W-1:0] gap_cnt;
    logic             grant_id;
    logic             owner_valid;
    logic             accept;
    logic             acc_id;
    logic             acc_last;
    logic [31:0]      acc_instr;
    logic             beat_end;
    logic             burst_done;

`ifdef FIXED_PRIO_EN
    always_comb grant_id = !req0_valid;
`else
    logic rr_ptr;

    always_comb grant_id = (req0_valid && req1_valid) ? rr_ptr : !req0_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (burst_done) begin
            rr_ptr <= !acc_id;
        end
    end
`endif

    // In IDLE the granted beat is accepted immediately and counts as beat 1.
    always_comb begin
        owner_valid = owner ? req1_valid : req0_valid;
        acc_id      = (state == IDLE) ? grant_id : owner;
        accept      = ((state == IDLE) && (req0_valid || req1_valid)) ||
                      ((state == BURST) && owner_valid);
        acc_last    = acc_id ? req1_last : req0_last;
        acc_instr   = acc_id ? req1_instr : req0_instr;
        cnt_next    = (state == IDLE) ? CNT_W'(1) : beat_cnt + 1'b1;
        beat_end    = acc_last || (cnt_next == BURST_MAX);
        burst_done  = (accept && beat_end) || ((state == BURST) && !owner_valid);
        req0_ready  = rst_n && accept && !acc_id;
        req1_ready  = rst_n && accept && acc_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            owner            <= 1'b0;
            beat_cnt         <= '0;
            gap_cnt          <= '0;
            core_in_valid    <= 1'b0;
            core_instruction <= '0;
            err_break        <= 1'b0;
        end else begin
            core_in_valid <= accept;
            if (accept) begin
                core_instruction <= acc_instr;
                beat_cnt         <= cnt_next;
            end
            if (burst_done) begin
                gap_cnt <= '0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= acc_id;
                        state <= beat_end ? GAP : BURST;
                    end
                end
                BURST: begin
                    if (!owner_valid) begin
                        err_break <= 1'b1;
                    end
                    if (burst_done) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mips_tag_pipe #(
        .CORE_LAT(CORE_LAT)
    ) u_tag_pipe (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .push_valid            (accept),
        .push_id               (acc_id),
        .push_last             (beat_end),
        .core_out_valid        (core_out_valid),
        .core_instruction_fail (core_instruction_fail),
        .rsp_valid             (rsp_valid),
        .rsp_id                (rsp_id),
        .rsp_fail              (rsp_fail),
        .rsp_last              (rsp_last),
        .err_orphan            (err_orphan)
    );

endmodule

// File: tb/tb_mips_burst_arbiter.sv
// Directed bench for mips_burst_arbiter with a two-cycle core model that fails
// any opcode other than R_TYPE or ADDI.
module tb_mips_burst_arbiter;
    import mips_arb_pkg::*;

    localparam int unsigned CORE_LAT   = 2;
    localparam int unsigned GAP_CYCLES = 1;
    localparam int unsigned MAX_BURST  = 16;

    localparam logic [31:0] I_ADD  = 32'h014B4820;
    localparam logic [31:0] I_ADDI = 32'h21490005;
    localparam logic [31:0] I_ORI  = 32'h35490005;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
    logic        req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
    logic [31:0] req0_instr = '0, req1_instr = '0;
    logic        core_in_valid, core_out_valid, core_instruction_fail;
    logic [31:0] core_instruction;
    logic        rsp_valid, rsp_id, rsp_fail, rsp_last, err_break, err_orphan;

    typedef struct { logic [31:0] instr; logic last; } beat_t;
    typedef struct { int cyc; logic id; logic fail; logic last; logic [31:0] instr; } ev_t;

    beat_t q0[$], q1[$];
    ev_t   acc_log[$], iss_log[$], rsp_log[$];
    int    cyc = 0, n_acc0 = 0, n_acc1 = 0, cap0 = 0, cap1 = 0;
    int    ab = 0, ib = 0, rb = 0;
    int    n_checks = 0, n_errors = 0;

    logic        d1_v = 1'b0, d2_v = 1'b0, force_ov = 1'b0;
    logic [31:0] d1_i = '0, d2_i = '0;

    mips_burst_arbiter #(
        .CORE_LAT  (CORE_LAT),
        .GAP_CYCLES(GAP_CYCLES),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_instr(req0_instr), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_instr(req1_instr), .req1_last(req1_last), .req1_ready(req1_ready),
        .core_in_valid(core_in_valid), .core_instruction(core_instruction),
        .core_out_valid(core_out_valid), .core_instruction_fail(core_instruction_fail),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_fail(rsp_fail), .rsp_last(rsp_last),
        .err_break(err_break), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model keeps running through arbiter reset so in-flight results still emerge.
    always @(posedge clk) begin
        d1_v <= core_in_valid;
        d1_i <= core_instruction;
        d2_v <= d1_v;
        d2_i <= d1_i;
    end
    assign core_out_valid        = d2_v || force_ov;
    assign core_instruction_fail = d2_v && !((d2_i[31:26] == R_TYPE) || (d2_i[31:26] == ADDI));

    always @(posedge clk) begin
        #1;
        req0_valid = (n_acc0 < q0.size()) && (n_acc0 < cap0);
        req0_instr = (n_acc0 < q0.size()) ? q0[n_acc0].instr : '0;
        req0_last  = (n_acc0 < q0.size()) ? q0[n_acc0].last : 1'b0;
        req1_valid = (n_acc1 < q1.size()) && (n_acc1 < cap1);
        req1_instr = (n_acc1 < q1.size()) ? q1[n_acc1].instr : '0;
        req1_last  = (n_acc1 < q1.size()) ? q1[n_acc1].last : 1'b0;
    end

    function automatic ev_t mk(input int c, input logic id, input logic fail,
                               input logic last, input logic [31:0] instr);
        ev_t e;
        e.cyc = c; e.id = id; e.fail = fail; e.last = last; e.instr = instr;
        return e;
    endfunction

    always @(negedge clk) begin
        if (req0_valid && req0_ready) begin
            acc_log.push_back(mk(cyc, 1'b0, 1'b0, req0_last, req0_instr));
            n_acc0++;
        end
        if (req1_valid && req1_ready) begin
            acc_log.push_back(mk(cyc, 1'b1, 1'b0, req1_last, req1_instr));
            n_acc1++;
        end
        if (core_in_valid) iss_log.push_back(mk(cyc, 1'b0, 1'b0, 1'b0, core_instruction));
        if (rsp_valid) rsp_log.push_back(mk(cyc, rsp_id, rsp_fail, rsp_last, '0));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        ab = acc_log.size();
        ib = iss_log.size();
        rb = rsp_log.size();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        mark();
    endtask

    task automatic push(input logic side, input logic [31:0] instr, input logic last);
        beat_t b;
        b.instr = instr;
        b.last  = last;
        if (side) q1.push_back(b);
        else q0.push_back(b);
    endtask

    initial begin
        logic [31:0] t1_instr [4];
        logic        t1_fail  [4];
        logic        t1_last  [4];
        logic        t2_id    [6];
        int          t2_off   [6];
        logic        t2_last  [6];

        t1_instr = '{I_ADD, I_ADDI, I_ORI, I_ADD};
        t1_fail  = '{1'b0, 1'b0, 1'b1, 1'b0};
        t1_last  = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef FIXED_PRIO_EN
        t2_id    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        t2_id    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
        t2_off   = '{0, 1, 3, 4, 6, 7};
        t2_last  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state with requester 0 already valid
        for (int i = 0; i < 4; i++) push(1'b0, t1_instr[i], t1_last[i]);
        cap0 = q0.size();
        @(posedge clk); #2;
        check("rst_ready0", req0_ready, 0);
        check("rst_civ", core_in_valid, 0);
        check("rst_instr", core_instruction, 0);
        check("rst_rsp", rsp_valid, 0);
        check("rst_err", {err_break, err_orphan}, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        mark();

        // Single 3-beat burst plus one more beat to measure the gap
        repeat (20) @(posedge clk);
        check("t1_acc_n", acc_log.size() - ab, 4);
        check("t1_iss_n", iss_log.size() - ib, 4);
        check("t1_rsp_n", rsp_log.size() - rb, 4);
        if (iss_log.size() - ib == 4 && rsp_log.size() - rb == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t1_instr", iss_log[ib+i].instr, t1_instr[i]);
                check("t1_rsp_id", rsp_log[rb+i].id, 0);
                check("t1_rsp_fail", rsp_log[rb+i].fail, t1_fail[i]);
                check("t1_rsp_last", rsp_log[rb+i].last, t1_last[i]);
            end
            check("t1_b2", iss_log[ib+1].cyc - iss_log[ib].cyc, 1);
            check("t1_b3", iss_log[ib+2].cyc - iss_log[ib].cyc, 2);
            check("t1_gap", iss_log[ib+3].cyc - iss_log[ib+2].cyc, 2);
            check("t1_lat", rsp_log[rb].cyc - iss_log[ib].cyc, 2);
        end

        // Both requesters valid from reset with 2-beat bursts
        do_reset();
        for (int i = 0; i < 4; i++) push(1'b0, I_ADD + 32'(i), (i % 2) == 1);
        for (int i = 0; i < 2; i++) push(1'b1, I_ADDI + 32'(i), i == 1);
        cap0 = q0.size();
        cap1 = q1.size();
        repeat (25) @(posedge clk);
        check("t2_acc_n", acc_log.size() - ab, 6);
        check("t2_rsp_n", rsp_log.size() - rb, 6);
        if (acc_log.size() - ab == 6 && rsp_log.size() - rb == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("t2_id", acc_log[ab+i].id, t2_id[i]);
                check("t2_off", acc_log[ab+i].cyc - acc_log[ab].cyc, t2_off[i]);
                check("t2_rsp_id", rsp_log[rb+i].id, t2_id[i]);
                check("t2_rsp_last", rsp_log[rb+i].last, t2_last[i]);
            end
        end

        // 20 beats with last only on beat 20: forced end after beat 16
        do_reset();
        for (int i = 0; i < 20; i++) push(1'b0, I_ADDI + 32'(i), i == 19);
        cap0 = q0.size();
        repeat (50) @(posedge clk);
        check("t3_iss_n", iss_log.size() - ib, 20);
        check("t3_rsp_n", rsp_log.size() - rb, 20);
        if (iss_log.size() - ib == 20 && rsp_log.size() - rb == 20) begin
            check("t3_span16", iss_log[ib+15].cyc - iss_log[ib].cyc, 15);
            check("t3_gap", iss_log[ib+16].cyc - iss_log[ib+15].cyc, 2);
            check("t3_span4", iss_log[ib+19].cyc - iss_log[ib+16].cyc, 3);
            check("t3_last15", rsp_log[rb+14].last, 0);
            check("t3_last16", rsp_log[rb+15].last, 1);
            check("t3_last17", rsp_log[rb+16].last, 0);
            check("t3_last20", rsp_log[rb+19].last, 1);
            check("t3_fail16", rsp_log[rb+15].fail, 0);
        end

        // Owner drops valid after beat 2 of 4
        do_reset();
        for (int i = 0; i < 4; i++) push(1'b0, I_ADD, i == 3);
        cap0 = n_acc0 + 2;
        repeat (8) @(posedge clk); #1;
        check("t4_brk", err_break, 1);
        check("t4_iss_n", iss_log.size() - ib, 2);
        check("t4_rsp_n", rsp_log.size() - rb, 2);
        if (rsp_log.size() - rb == 2) check("t4_rsp_last", rsp_log[rb+1].last, 0);
        cap0 = q0.size();
        repeat (12) @(posedge clk); #1;
        check("t4_iss_n2", iss_log.size() - ib, 4);
        check("t4_rsp_n2", rsp_log.size() - rb, 4);
        if (rsp_log.size() - rb == 4) check("t4_rsp_last2", rsp_log[rb+3].last, 1);
        check("t4_brk_sticky", err_break, 1);
        do_reset();
        check("t4_brk_clr", err_break, 0);

        // Orphan result while idle
        @(posedge clk); #1 force_ov = 1'b1;
        @(negedge clk);
        check("t5_rsp", rsp_valid, 0);
        check("t5_orph_pre", err_orphan, 0);
        @(posedge clk); #1 force_ov = 1'b0;
        check("t5_orph", err_orphan, 1);
        check("t5_rsp_n", rsp_log.size() - rb, 0);

        // Asynchronous reset in the middle of a burst
        mark();
        for (int i = 0; i < 10; i++) push(1'b0, I_ADDI, i == 9);
        cap0 = q0.size();
        repeat (5) @(posedge clk); #2;
        check("t6_mid_civ", core_in_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_civ", core_in_valid, 0);
        check("t6_instr", core_instruction, 0);
        check("t6_rsp", {rsp_valid, rsp_id, rsp_fail, rsp_last}, 0);
        check("t6_ready", {req0_ready, req1_ready}, 0);
        check("t6_err", {err_break, err_orphan}, 0);
        cap0 = n_acc0;
        @(posedge clk); #3 rst_n = 1'b1;
        mark();
        repeat (4) @(posedge clk); #1;
        check("t6_rsp_n", rsp_log.size() - rb, 0);
        check("t6_acc_n", acc_log.size() - ab, 0);
        check("t6_orph", err_orphan, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
